// File: rtl/db_pkg.sv
// Shared definitions for the deblocking LCU pixel RAM blocks.
package db_pkg;

  localparam int DB_LCU_DATA_W = 128;
  localparam int DB_LCU_ADDR_W = 8;

  typedef enum logic [1:0] {
    DB_ST_IDLE = 2'd0,
    DB_ST_RUN  = 2'd1,
    DB_ST_DONE = 2'd2
  } db_state_e;

endpackage

// File: rtl/db_skid_fifo2.sv
// Two-entry skid FIFO catching RAM read returns while the stream is stalled.
// Push and pop in the same cycle are accepted at any fill level, including full.
module db_skid_fifo2
  import db_pkg::*;
#(
  parameter int DATA_WIDTH = DB_LCU_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            cnt_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && (cnt_q != 2'd0);
    // When full, the slot being written is the one leaving this cycle.
    do_push  = push_i && ((cnt_q != 2'd2) || do_pop);

    if (do_push) begin
      if (wr_ptr_q) begin
        ent1_d = push_data_i;
      end else begin
        ent0_d = push_data_i;
      end
      wr_ptr_d = ~wr_ptr_q;
    end

    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = rd_ptr_q ? ent1_q : ent0_q;

endmodule

// File: rtl/db_lcu_ram_rd.sv
// Read-side controller for the deblocking LCU pixel RAM: fetches a burst of
// consecutive rows and streams them out over valid/ready.
//
//  state | meaning
//  IDLE  | waiting for start_i; RAM port parked
//  RUN   | issuing reads under FIFO credit, streaming beats
//  DONE  | burst complete; done_o pulses for one cycle
module db_lcu_ram_rd
  import db_pkg::*;
#(
  parameter int DATA_WIDTH = DB_LCU_DATA_W,
  parameter int ADDR_WIDTH = DB_LCU_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  cen_o,
  output logic                  ren_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = ADDR_WIDTH + 1;

  db_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         popped_q, popped_d;
  logic                  inflight_q, inflight_d;

  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  pop;
  logic [2:0]            occ;

  db_skid_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (ram_data_i),
    .pop_i       (pop),
    .cnt_o       (fifo_cnt),
    .head_o      (fifo_head)
  );

  assign valid_o = (fifo_cnt != 2'd0);
  assign data_o  = fifo_head;
  assign pop     = valid_o && ready_i;
  assign wen_o   = 1'b1;
  assign busy_o  = (state_q != DB_ST_IDLE);

  // Slots committed after this edge: stored beats plus the read in flight,
  // less the beat leaving now. pop implies fifo_cnt>=1, so no underflow.
  assign occ = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  // Controller next-state, read issue under credit, and RAM port drive.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    cen_o      = 1'b1;
    ren_o      = 1'b1;
    addr_o     = '0;
    done_o     = 1'b0;

    case (state_q)
      DB_ST_IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          popped_d = '0;
          state_d  = (len_i != '0) ? DB_ST_RUN : DB_ST_DONE;
        end
      end
      DB_ST_RUN: begin
        ren_o  = 1'b0;
        addr_o = base_q + issued_q[ADDR_WIDTH-1:0];
        if ((issued_q < len_q) && (occ < 3'd2)) begin
          cen_o    = 1'b0;
          issued_d = issued_q + CW'(1);
        end
        if (pop) begin
          popped_d = popped_q + CW'(1);
          if (popped_d == len_q) begin
            state_d = DB_ST_DONE;
          end
        end
      end
      DB_ST_DONE: begin
        done_o  = 1'b1;
        state_d = DB_ST_IDLE;
      end
      default: begin
        state_d = DB_ST_IDLE;
      end
    endcase

    inflight_d = ~cen_o;
  end

  // Controller state, burst parameters and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DB_ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
